// File: rtl/mycpu_io_if.sv
// CPU I/O-space bus plus the RX (valid/ready in) and TX (valid/ready out) streams of mycpu_io.
// master = CPU/stream side, slave = the I/O block.
interface mycpu_io_if;
  logic [15:0] addr_in;
  logic [15:0] d_in;
  logic        wen_in;
  logic        iom_in;
  logic [15:0] io_out;
  logic [15:0] rx_data_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic [15:0] tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;

  modport master (
    output addr_in, d_in, wen_in, iom_in, rx_data_in, rx_valid_in, tx_ready_in,
    input  io_out, rx_ready_out, tx_data_out, tx_valid_out
  );

  modport slave (
    input  addr_in, d_in, wen_in, iom_in, rx_data_in, rx_valid_in, tx_ready_in,
    output io_out, rx_ready_out, tx_data_out, tx_valid_out
  );
endinterface

// File: rtl/mycpu_io.sv
// Memory-mapped I/O block: RX FIFO, TX holding register, GPO/GPI and a reloadable down-counter,
// decoded from CPU I/O cycles with combinational read data.
module mycpu_io #(
  parameter int unsigned RX_DEPTH = 4,
  parameter logic [11:0] BASE_HI  = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  mycpu_io_if.slave   bus,
  output logic [15:0] gpo_out,
  input  logic [15:0] gpi_in,
  output logic        tmr_exp_out
);

  localparam int unsigned AW = $clog2(RX_DEPTH);

  logic        sel, wr;
  logic [3:0]  reg_addr;
  logic        rx_pop_req, rx_pop, rx_push, rx_empty, rx_full;
  logic        st_wr, tx_wr, tx_hs, tmr_wr, tmr_fire;
  logic [15:0] status, rx_head;

  logic [15:0] rx_mem_q [RX_DEPTH];
  logic [AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic        rx_under_q, rx_under_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_drop_q, tx_drop_d;
  logic [15:0] gpo_q, gpo_d;
  logic [15:0] gpi_s1_q, gpi_s2_q;
  logic [15:0] tmr_reload_q, tmr_reload_d, tmr_count_q, tmr_count_d;
  logic        tmr_pulse_q, tmr_exp_q, tmr_exp_d;

  assign sel      = bus.iom_in & (bus.addr_in[15:4] == BASE_HI);
  assign wr       = sel & bus.wen_in;
  assign reg_addr = bus.addr_in[3:0];

  // Extra pointer MSB distinguishes full from empty.
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_head  = rx_empty ? 16'h0000 : rx_mem_q[rx_rptr_q[AW-1:0]];

  assign rx_pop_req = wr & (reg_addr == 4'h0);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_push    = bus.rx_valid_in & bus.rx_ready_out;
  assign st_wr      = wr & (reg_addr == 4'h1);
  assign tx_wr      = wr & (reg_addr == 4'h2);
  assign tmr_wr     = wr & (reg_addr == 4'h5);
  assign tx_hs      = tx_valid_q & bus.tx_ready_in;
  assign tmr_fire   = (tmr_reload_q != 16'h0000) & (tmr_count_q == 16'h0001) & ~tmr_wr;

  assign status = {10'b0, tx_drop_q, tmr_exp_q, tx_valid_q, rx_under_q, rx_full, rx_empty};

  always_comb begin
    rx_wptr_d    = rx_wptr_q;
    rx_rptr_d    = rx_rptr_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    gpo_d        = gpo_q;
    tmr_reload_d = tmr_reload_q;
    tmr_count_d  = tmr_count_q;

    if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
    if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;

    // A write while valid (including a handshake-completing cycle) is dropped.
    if (tx_hs) tx_valid_d = 1'b0;
    if (tx_wr && !tx_valid_q) begin
      tx_data_d  = bus.d_in;
      tx_valid_d = 1'b1;
    end

    if (wr && reg_addr == 4'h3) gpo_d = bus.d_in;

    if (tmr_wr) begin
      tmr_reload_d = bus.d_in;
      tmr_count_d  = bus.d_in;
    end else if (tmr_reload_q != 16'h0000) begin
      tmr_count_d = tmr_fire ? tmr_reload_q : tmr_count_q - 16'h0001;
    end

    // Sticky bits: set wins over write-1-to-clear.
    rx_under_d = (rx_pop_req & rx_empty) | (rx_under_q & ~(st_wr & bus.d_in[2]));
    tmr_exp_d  = tmr_fire | (tmr_exp_q & ~(st_wr & bus.d_in[4]));
    tx_drop_d  = (tx_wr & tx_valid_q) | (tx_drop_q & ~(st_wr & bus.d_in[5]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_under_q   <= 1'b0;
      tx_data_q    <= 16'h0000;
      tx_valid_q   <= 1'b0;
      tx_drop_q    <= 1'b0;
      gpo_q        <= 16'h0000;
      gpi_s1_q     <= 16'h0000;
      gpi_s2_q     <= 16'h0000;
      tmr_reload_q <= 16'h0000;
      tmr_count_q  <= 16'h0000;
      tmr_pulse_q  <= 1'b0;
      tmr_exp_q    <= 1'b0;
    end else begin
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      rx_under_q   <= rx_under_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_drop_q    <= tx_drop_d;
      gpo_q        <= gpo_d;
      gpi_s1_q     <= gpi_in;
      gpi_s2_q     <= gpi_s1_q;
      tmr_reload_q <= tmr_reload_d;
      tmr_count_q  <= tmr_count_d;
      tmr_pulse_q  <= tmr_fire;
      tmr_exp_q    <= tmr_exp_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= bus.rx_data_in;
  end

  always_comb begin
    bus.io_out = 16'h0000;
    if (sel) begin
      case (reg_addr)
        4'h0:    bus.io_out = rx_head;
        4'h1:    bus.io_out = status;
        4'h2:    bus.io_out = tx_data_q;
        4'h3:    bus.io_out = gpo_q;
        4'h4:    bus.io_out = gpi_s2_q;
        4'h5:    bus.io_out = tmr_count_q;
        default: bus.io_out = 16'h0000;
      endcase
    end
  end

  assign bus.rx_ready_out = ~rx_full & ~rst;
  assign bus.tx_data_out  = tx_data_q;
  assign bus.tx_valid_out = tx_valid_q;
  assign gpo_out          = gpo_q;
  assign tmr_exp_out      = tmr_pulse_q & ~rst;

endmodule

// File: tb/tb_mycpu_io.sv
// Directed bench for mycpu_io: stimulus queues expected values, a negedge monitor compares them.
module tb_mycpu_io;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpo_out;
  logic [15:0] gpi_in;
  logic        tmr_exp_out;

  mycpu_io_if bus ();

  mycpu_io #(.RX_DEPTH(4), .BASE_HI(12'h000)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .gpo_out     (gpo_out),
    .gpi_in      (gpi_in),
    .tmr_exp_out (tmr_exp_out)
  );

  always #5 clk = ~clk;

  // Observation selectors
  localparam int SelIo = 0, SelRxRdy = 1, SelTxVld = 2, SelTxDat = 3, SelGpo = 4, SelTmr = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        mon_e;
  logic [15:0] mon_got;

  function automatic logic [15:0] sample(input int sel);
    case (sel)
      SelIo:    return bus.io_out;
      SelRxRdy: return {15'b0, bus.rx_ready_out};
      SelTxVld: return {15'b0, bus.tx_valid_out};
      SelTxDat: return bus.tx_data_out;
      SelGpo:   return gpo_out;
      default:  return {15'b0, tmr_exp_out};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_got = sample(mon_e.sel);
      n_cmp++;
      if (mon_got !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%04h, expected 0x%04h", mon_e.name, mon_got, mon_e.exp);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [15:0] v, input string name);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic chk(input int sel, input logic [15:0] v, input string name);
    logic [15:0] got;
    expect_val(sel, v, name);
    @(negedge clk);
    #1;
    got = sample(sel);
    n_cmp++;
    if (got !== v) begin
      n_bad++;
      $display("FAIL %s (direct): got 0x%04h, expected 0x%04h", name, got, v);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.iom_in  = 1'b1;
    bus.wen_in  = 1'b1;
    bus.addr_in = a;
    bus.d_in    = d;
    @(posedge clk);
    #1;
    bus.iom_in = 1'b0;
    bus.wen_in = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] v, input string name);
    logic [15:0] got;
    bus.iom_in  = 1'b1;
    bus.wen_in  = 1'b0;
    bus.addr_in = a;
    expect_val(SelIo, v, name);
    @(negedge clk);
    #1;
    got = bus.io_out;
    n_cmp++;
    if (got !== v) begin
      n_bad++;
      $display("FAIL %s (direct): got 0x%04h, expected 0x%04h", name, got, v);
    end
    bus.iom_in = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    bus.rx_data_in  = d;
    bus.rx_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    gpi_in          = 16'h0000;
    bus.addr_in     = 16'h0000;
    bus.d_in        = 16'h0000;
    bus.wen_in      = 1'b0;
    bus.iom_in      = 1'b0;
    bus.rx_data_in  = 16'h9999;
    bus.rx_valid_in = 1'b1;
    bus.tx_ready_in = 1'b0;

    // 1: reset with rx_valid held high
    chk(SelRxRdy, 16'h0, "rst_rx_ready");
    chk(SelTmr, 16'h0, "rst_tmr_exp");
    rst = 1'b0;
    bus.rx_valid_in = 1'b0;
    rd(16'h0001, 16'h0001, "rst_status");
    rd(16'h0000, 16'h0000, "rst_rxdata_empty");
    chk(SelGpo, 16'h0, "rst_gpo");
    chk(SelTxVld, 16'h0, "rst_tx_valid");

    // 2: fill, drain, underflow, W1C
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    chk(SelRxRdy, 16'h0, "full_rx_ready");
    rd(16'h0001, 16'h0002, "full_status");
    rd(16'h0000, 16'h1111, "head0");
    wr(16'h0000, 16'h0000);
    chk(SelRxRdy, 16'h1, "pop_frees_slot");
    rd(16'h0000, 16'h2222, "head1");
    wr(16'h0000, 16'h0000);
    wr(16'h0000, 16'h0000);
    wr(16'h0000, 16'h0000);
    rd(16'h0001, 16'h0001, "drained_status");
    wr(16'h0000, 16'h0000);
    rd(16'h0001, 16'h0005, "under_status");
    wr(16'h0001, 16'h0004);
    rd(16'h0001, 16'h0001, "under_cleared");

    // 3: TX register
    wr(16'h0002, 16'hABCD);
    chk(SelTxVld, 16'h1, "tx_valid_set");
    chk(SelTxDat, 16'hABCD, "tx_data_load");
    rd(16'h0001, 16'h0009, "tx_busy_status");
    wr(16'h0002, 16'h1234);
    chk(SelTxDat, 16'hABCD, "tx_data_kept");
    rd(16'h0001, 16'h0029, "tx_drop_status");
    rd(16'h0002, 16'hABCD, "txdata_read");
    bus.tx_ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_ready_in = 1'b0;
    chk(SelTxVld, 16'h0, "tx_handshake");
    wr(16'h0001, 16'h0020);
    rd(16'h0001, 16'h0001, "tx_drop_cleared");
    wr(16'h0002, 16'h5555);
    bus.tx_ready_in = 1'b1;
    wr(16'h0002, 16'h6666);
    bus.tx_ready_in = 1'b0;
    chk(SelTxVld, 16'h0, "collide_valid");
    chk(SelTxDat, 16'h5555, "collide_data");
    rd(16'h0001, 16'h0021, "collide_drop");
    wr(16'h0001, 16'h0020);

    // 4: timer, period 3
    wr(16'h0005, 16'h0003);
    rd(16'h0005, 16'h0003, "tmr_loaded");
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk(SelTmr, (k % 3 == 0) ? 16'h1 : 16'h0, $sformatf("tmr_cycle%0d", k));
    end
    rd(16'h0001, 16'h0011, "tmr_exp_status");
    wr(16'h0005, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk(SelTmr, 16'h0, $sformatf("tmr_stopped%0d", k));
    end
    rd(16'h0005, 16'h0000, "tmr_count_zero");
    wr(16'h0001, 16'h0010);
    rd(16'h0001, 16'h0001, "tmr_exp_cleared");

    // 5: decode qualification
    bus.iom_in  = 1'b0;
    bus.wen_in  = 1'b1;
    bus.addr_in = 16'h0003;
    bus.d_in    = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.wen_in = 1'b0;
    chk(SelGpo, 16'h0000, "gpo_no_iom");
    wr(16'h0013, 16'hFFFF);
    chk(SelGpo, 16'h0000, "gpo_wrong_base");
    rd(16'h0013, 16'h0000, "read_wrong_base");
    wr(16'h0003, 16'hFFFF);
    chk(SelGpo, 16'hFFFF, "gpo_write");
    rd(16'h0003, 16'hFFFF, "gpo_read");
    rd(16'h0007, 16'h0000, "unmapped_read");

    // 6: GPI synchroniser latency, simultaneous push/pop
    @(posedge clk);
    #1;
    gpi_in = 16'h00FF;
    rd(16'h0004, 16'h0000, "gpi_edge0");
    @(posedge clk);
    #1;
    rd(16'h0004, 16'h0000, "gpi_edge1");
    @(posedge clk);
    #1;
    rd(16'h0004, 16'h00FF, "gpi_edge2");
    push(16'hAAAA);
    push(16'hBBBB);
    bus.rx_data_in  = 16'hCCCC;
    bus.rx_valid_in = 1'b1;
    wr(16'h0000, 16'h0000);
    bus.rx_valid_in = 1'b0;
    rd(16'h0001, 16'h0000, "pushpop_status");
    rd(16'h0000, 16'hBBBB, "pushpop_head");
    wr(16'h0000, 16'h0000);
    rd(16'h0000, 16'hCCCC, "pushpop_order");
    wr(16'h0000, 16'h0000);
    rd(16'h0001, 16'h0001, "pushpop_drained");

    // Reset mid-operation drops FIFO contents and pending TX
    push(16'h7777);
    wr(16'h0002, 16'h4242);
    rst = 1'b1;
    chk(SelRxRdy, 16'h0, "midrst_rx_ready");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(16'h0001, 16'h0001, "midrst_status");
    rd(16'h0000, 16'h0000, "midrst_rxdata");
    chk(SelTxVld, 16'h0, "midrst_tx_valid");
    chk(SelGpo, 16'h0000, "midrst_gpo");

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
